// File: rtl/mdp_msg_framer.sv
// CME MDP 3.0 packet framer: captures the packet header, walks the little-endian
// MsgSize chain and emits one descriptor per SBE message plus per-packet end pulses.
module mdp_msg_framer #(
  parameter int unsigned MIN_MSG_SIZE = 10,
  parameter int unsigned IDX_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      in_data,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [2:0]       in_empty,
  output logic             in_ready,
  output logic             msg_valid,
  output logic [31:0]      msg_seq_num,
  output logic [63:0]      msg_sending_time,
  output logic [15:0]      msg_size,
  output logic [15:0]      msg_template_id,
  output logic [IDX_W-1:0] msg_index,
  output logic             pkt_done,
  output logic [IDX_W-1:0] pkt_msg_count,
  output logic             pkt_error,
  output logic [2:0]       pkt_err_code
);

  localparam logic [2:0] ERR_SHORT   = 3'd1;
  localparam logic [2:0] ERR_BADSIZE = 3'd2;
  localparam logic [2:0] ERR_TRUNC   = 3'd3;
  localparam logic [2:0] ERR_ABORT   = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_MSGS, S_DROP} state_e;

  state_e           state_q, state_d;
  logic [15:0]      word_base_q, word_base_d;
  logic [16:0]      next_ptr_q, next_ptr_d;
  logic [63:0]      prev_word_q, prev_word_d;
  logic [31:0]      seq_q, seq_d;
  logic [63:0]      time_q, time_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic             msg_valid_q, msg_valid_d;
  logic [31:0]      msg_seq_num_q, msg_seq_num_d;
  logic [63:0]      msg_sending_time_q, msg_sending_time_d;
  logic [15:0]      msg_size_q, msg_size_d;
  logic [15:0]      msg_template_id_q, msg_template_id_d;
  logic [IDX_W-1:0] msg_index_q, msg_index_d;
  logic             pkt_done_q, pkt_done_d;
  logic [IDX_W-1:0] pkt_msg_count_q, pkt_msg_count_d;
  logic             pkt_error_q, pkt_error_d;
  logic [2:0]       pkt_err_code_q, pkt_err_code_d;

  // Byte k of the 16-byte window {prev_word, in_data}; byte 0 is the oldest.
  function automatic logic [7:0] win_byte(input logic [127:0] win, input logic [3:0] k);
    return win[{~k, 3'b111} -: 8];
  endfunction

  logic [127:0]     win;
  logic [16:0]      nptr;
  logic [17:0]      diff;
  logic [3:0]       off;
  logic             in_win;
  logic [16:0]      pkt_len;
  logic             fits;
  logic             hit;
  logic [15:0]      fld_size;
  logic [15:0]      fld_tid;
  logic [17:0]      sum;
  logic             bad;
  logic [IDX_W-1:0] cnt_inc;
  logic [31:0]      lo_le32;
  logic [31:0]      hi_le32;

  // Window offset of the pending message start; in range 0..15 when it lies in prev or current word.
  assign win      = {prev_word_q, in_data};
  assign nptr     = (state_q == S_HDR) ? 17'd12 : next_ptr_q;
  assign diff     = 18'(nptr) + 18'd8 - 18'(word_base_q);
  assign off      = diff[3:0];
  assign in_win   = diff < 18'd16;
  assign pkt_len  = 17'(word_base_q) + 17'd8 - 17'(in_empty);
  assign fits     = !in_eop || ((nptr + 17'd6) <= pkt_len);
  assign hit      = in_win && (off <= 4'd10) && fits;
  assign fld_size = {win_byte(win, off + 4'd1), win_byte(win, off)};
  assign fld_tid  = {win_byte(win, off + 4'd5), win_byte(win, off + 4'd4)};
  assign sum      = 18'(nptr) + 18'(fld_size);
  assign bad      = (fld_size < 16'(MIN_MSG_SIZE)) || (sum[17:16] != 2'b00);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + IDX_W'(1);
  assign lo_le32  = {in_data[39:32], in_data[47:40], in_data[55:48], in_data[63:56]};
  assign hi_le32  = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};

  always_comb begin
    state_d            = state_q;
    word_base_d        = word_base_q;
    next_ptr_d         = next_ptr_q;
    prev_word_d        = prev_word_q;
    seq_d              = seq_q;
    time_d             = time_q;
    cnt_d              = cnt_q;
    msg_valid_d        = 1'b0;
    msg_seq_num_d      = msg_seq_num_q;
    msg_sending_time_d = msg_sending_time_q;
    msg_size_d         = msg_size_q;
    msg_template_id_d  = msg_template_id_q;
    msg_index_d        = msg_index_q;
    pkt_done_d         = 1'b0;
    pkt_msg_count_d    = pkt_msg_count_q;
    pkt_error_d        = 1'b0;
    pkt_err_code_d     = pkt_err_code_q;

    if (in_valid) begin
      prev_word_d = in_data;
      word_base_d = word_base_q + 16'd8;
      if (in_sop) begin
        // A sop always restarts parsing; an open packet is reported as aborted.
        seq_d        = lo_le32;
        time_d[31:0] = hi_le32;
        cnt_d        = '0;
        word_base_d  = 16'd8;
        next_ptr_d   = 17'd12;
        state_d      = in_eop ? S_IDLE : S_HDR;
        if (state_q != S_IDLE) begin
          pkt_error_d     = 1'b1;
          pkt_err_code_d  = ERR_ABORT;
          pkt_msg_count_d = cnt_q;
        end else if (in_eop) begin
          pkt_error_d     = 1'b1;
          pkt_err_code_d  = ERR_SHORT;
          pkt_msg_count_d = '0;
        end
      end else begin
        case (state_q)
          S_IDLE: ;
          S_DROP: if (in_eop) state_d = S_IDLE;
          default: begin
            if (state_q == S_HDR) time_d[63:32] = lo_le32;
            if ((state_q == S_HDR) && in_eop && (in_empty > 3'd4)) begin
              pkt_error_d     = 1'b1;
              pkt_err_code_d  = ERR_SHORT;
              pkt_msg_count_d = cnt_q;
              state_d         = S_IDLE;
            end else if (hit && bad) begin
              pkt_error_d     = 1'b1;
              pkt_err_code_d  = ERR_BADSIZE;
              pkt_msg_count_d = cnt_q;
              state_d         = in_eop ? S_IDLE : S_DROP;
            end else begin
              state_d    = in_eop ? S_IDLE : S_MSGS;
              next_ptr_d = nptr;
              if (hit) begin
                msg_valid_d        = 1'b1;
                msg_seq_num_d      = seq_q;
                msg_sending_time_d = time_q;
                msg_size_d         = fld_size;
                msg_template_id_d  = fld_tid;
                msg_index_d        = cnt_q;
                cnt_d              = cnt_inc;
                next_ptr_d         = sum[16:0];
              end
              if (in_eop) begin
                pkt_msg_count_d = hit ? cnt_inc : cnt_q;
                if (next_ptr_d == pkt_len) begin
                  pkt_done_d = 1'b1;
                end else begin
                  pkt_error_d    = 1'b1;
                  pkt_err_code_d = ERR_TRUNC;
                end
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= S_IDLE;
      word_base_q        <= '0;
      next_ptr_q         <= '0;
      prev_word_q        <= '0;
      seq_q              <= '0;
      time_q             <= '0;
      cnt_q              <= '0;
      msg_valid_q        <= 1'b0;
      msg_seq_num_q      <= '0;
      msg_sending_time_q <= '0;
      msg_size_q         <= '0;
      msg_template_id_q  <= '0;
      msg_index_q        <= '0;
      pkt_done_q         <= 1'b0;
      pkt_msg_count_q    <= '0;
      pkt_error_q        <= 1'b0;
      pkt_err_code_q     <= '0;
    end else begin
      state_q            <= state_d;
      word_base_q        <= word_base_d;
      next_ptr_q         <= next_ptr_d;
      prev_word_q        <= prev_word_d;
      seq_q              <= seq_d;
      time_q             <= time_d;
      cnt_q              <= cnt_d;
      msg_valid_q        <= msg_valid_d;
      msg_seq_num_q      <= msg_seq_num_d;
      msg_sending_time_q <= msg_sending_time_d;
      msg_size_q         <= msg_size_d;
      msg_template_id_q  <= msg_template_id_d;
      msg_index_q        <= msg_index_d;
      pkt_done_q         <= pkt_done_d;
      pkt_msg_count_q    <= pkt_msg_count_d;
      pkt_error_q        <= pkt_error_d;
      pkt_err_code_q     <= pkt_err_code_d;
    end
  end

  assign in_ready         = 1'b1;
  assign msg_valid        = msg_valid_q;
  assign msg_seq_num      = msg_seq_num_q;
  assign msg_sending_time = msg_sending_time_q;
  assign msg_size         = msg_size_q;
  assign msg_template_id  = msg_template_id_q;
  assign msg_index        = msg_index_q;
  assign pkt_done         = pkt_done_q;
  assign pkt_msg_count    = pkt_msg_count_q;
  assign pkt_error        = pkt_error_q;
  assign pkt_err_code     = pkt_err_code_q;

endmodule

// File: tb/tb_mdp_msg_framer.sv
// Bench for mdp_msg_framer: packets are built as byte queues and the expected
// descriptors/end events are derived by walking the MsgSize chain over those bytes.
module tb_mdp_msg_framer;

  localparam int MIN = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic        in_valid, in_sop, in_eop;
  logic [2:0]  in_empty;
  logic        in_ready, msg_valid, pkt_done, pkt_error;
  logic [31:0] msg_seq_num;
  logic [63:0] msg_sending_time;
  logic [15:0] msg_size, msg_template_id;
  logic [7:0]  msg_index, pkt_msg_count;
  logic [2:0]  pkt_err_code;

  always #5 clk = ~clk;

  mdp_msg_framer #(.MIN_MSG_SIZE(MIN), .IDX_W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .in_ready(in_ready),
    .msg_valid(msg_valid), .msg_seq_num(msg_seq_num), .msg_sending_time(msg_sending_time),
    .msg_size(msg_size), .msg_template_id(msg_template_id), .msg_index(msg_index),
    .pkt_done(pkt_done), .pkt_msg_count(pkt_msg_count), .pkt_error(pkt_error),
    .pkt_err_code(pkt_err_code)
  );

  typedef struct packed {
    logic [31:0] seq;
    logic [63:0] tm;
    logic [15:0] size;
    logic [15:0] tid;
    logic [7:0]  idx;
  } desc_t;

  typedef struct {
    logic [63:0] data;
    bit          sop;
    bit          eop;
    logic [2:0]  empty;
    bit          mv;
    desc_t       d;
    int          endk;   // 0 none, 1 done, 2 error
    logic [2:0]  code;
    logic [7:0]  cnt;
  } step_t;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  pb[$];
  step_t       steps[$];
  bit          abort_pend = 0;
  logic [7:0]  abort_cnt = 0;
  desc_t       last_d = '0;
  logic [2:0]  last_code = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sat8(input int n);
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  function automatic step_t idle_step();
    step_t s;
    s.data = '0; s.sop = 0; s.eop = 0; s.empty = '0; s.mv = 0;
    s.d = '0; s.endk = 0; s.code = '0; s.cnt = '0;
    return s;
  endfunction

  task automatic put_hdr(input logic [31:0] seq, input logic [63:0] tm);
    pb.delete();
    for (int i = 0; i < 4; i++) pb.push_back(seq[8*i +: 8]);
    for (int i = 0; i < 8; i++) pb.push_back(tm[8*i +: 8]);
  endtask

  task automatic put_msg(input int size, input logic [15:0] tid, input logic [15:0] blen);
    logic [15:0] sz16;
    sz16 = 16'(size);
    pb.push_back(sz16[7:0]);  pb.push_back(sz16[15:8]);
    pb.push_back(blen[7:0]);  pb.push_back(blen[15:8]);
    pb.push_back(tid[7:0]);   pb.push_back(tid[15:8]);
    for (int i = 6; i < size; i++) pb.push_back(8'($urandom));
  endtask

  // Turn pb into words and expected events; send only the first nsend words.
  task automatic add_pkt(input int nsend);
    int L, nw, p, n, w, sz, tid, nab;
    logic [31:0] seq;
    logic [63:0] tm;
    step_t ev[];
    L = pb.size();
    nw = (L + 7) / 8;
    ev = new[nw];
    for (int i = 0; i < nw; i++) begin
      ev[i] = idle_step();
      for (int k = 0; k < 8; k++)
        ev[i].data[63-8*k -: 8] = (8*i + k < L) ? pb[8*i + k] : 8'($urandom);
      ev[i].sop = (i == 0);
      ev[i].eop = (i == nw - 1);
      ev[i].empty = ev[i].eop ? 3'(nw*8 - L) : 3'($urandom);
    end
    if (nw == 1) begin
      ev[0].endk = 2; ev[0].code = 3'd1; ev[0].cnt = 0;
    end else if (L < 12) begin
      ev[1].endk = 2; ev[1].code = 3'd1; ev[1].cnt = 0;
    end else begin
      seq = {pb[3], pb[2], pb[1], pb[0]};
      tm  = {pb[11], pb[10], pb[9], pb[8], pb[7], pb[6], pb[5], pb[4]};
      p = 12;
      n = 0;
      forever begin
        if (p + 6 > L) begin
          ev[nw-1].endk = (p == L) ? 1 : 2;
          ev[nw-1].code = 3'd3;
          ev[nw-1].cnt  = sat8(n);
          break;
        end
        sz  = int'({pb[p+1], pb[p]});
        tid = int'({pb[p+5], pb[p+4]});
        w   = (p + 5) / 8;
        if (sz < MIN || p + sz > 65535) begin
          ev[w].endk = 2; ev[w].code = 3'd2; ev[w].cnt = sat8(n);
          break;
        end
        ev[w].mv = 1;
        ev[w].d.seq = seq; ev[w].d.tm = tm; ev[w].d.size = 16'(sz);
        ev[w].d.tid = 16'(tid); ev[w].d.idx = sat8(n);
        n++;
        p += sz;
      end
    end
    if (abort_pend) begin
      ev[0].endk = 2; ev[0].code = 3'd4; ev[0].cnt = abort_cnt;
      abort_pend = 0;
    end
    if (nsend < nw) begin
      nab = 0;
      for (int i = 0; i < nsend; i++) if (ev[i].mv) nab++;
      abort_pend = 1;
      abort_cnt = sat8(nab);
    end
    for (int i = 0; i < nsend && i < nw; i++) steps.push_back(ev[i]);
  endtask

  task automatic check_step(input step_t s);
    chk("msg_valid", 64'(msg_valid), 64'(s.mv));
    if (s.mv) last_d = s.d;
    chk("msg_seq_num", 64'(msg_seq_num), 64'(last_d.seq));
    chk("msg_sending_time", msg_sending_time, last_d.tm);
    chk("msg_size", 64'(msg_size), 64'(last_d.size));
    chk("msg_template_id", 64'(msg_template_id), 64'(last_d.tid));
    chk("msg_index", 64'(msg_index), 64'(last_d.idx));
    chk("pkt_done", 64'(pkt_done), 64'(s.endk == 1));
    chk("pkt_error", 64'(pkt_error), 64'(s.endk == 2));
    if (s.endk != 0) chk("pkt_msg_count", 64'(pkt_msg_count), 64'(s.cnt));
    if (s.endk == 2) last_code = s.code;
    chk("pkt_err_code", 64'(pkt_err_code), 64'(last_code));
    chk("in_ready", 64'(in_ready), 64'd1);
  endtask

  // Drive queued words with `gap` idle cycles after each; check every cycle.
  task automatic play(input int gap);
    foreach (steps[i]) begin
      in_valid = 1'b1;
      in_data  = steps[i].data;
      in_sop   = steps[i].sop;
      in_eop   = steps[i].eop;
      in_empty = steps[i].empty;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      in_sop   = 1'($urandom);
      in_eop   = 1'($urandom);
      in_empty = 3'($urandom);
      check_step(steps[i]);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        check_step(idle_step());
      end
    end
    steps.delete();
    @(posedge clk); #1;
    check_step(idle_step());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    last_d = '0;
    last_code = '0;
    abort_pend = 0;
    chk("rst_pkt_msg_count", 64'(pkt_msg_count), 64'd0);
    check_step(idle_step());
  endtask

  task automatic nominal();
    put_hdr(32'h0000_0457, 64'h0123_4567_89AB_CDEF);
    put_msg(48, 16'h0020, 16'h0000);
  endtask

  initial begin
    step_t s;
    int nm, nw, nsend;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 0; in_eop = 0; in_empty = '0;
    @(posedge clk); #1;
    do_reset();

    // Stray non-sop word in IDLE
    s = idle_step(); s.data = 64'hDEAD_BEEF_0000_0001; s.eop = 1;
    steps.push_back(s);
    play(0);

    nominal(); add_pkt(1000); play(0);
    nominal(); add_pkt(1000); play(3);

    // Two back-to-back 10-byte messages, L = 32
    put_hdr($urandom, {$urandom, $urandom});
    put_msg(10, 16'h1111, 16'h0004);
    put_msg(10, 16'h2222, 16'h0004);
    add_pkt(1000); play(0);

    // Header only, L = 12
    put_hdr($urandom, {$urandom, $urandom});
    add_pkt(1000); play(1);

    // MsgSize 4, then a good packet
    put_hdr($urandom, {$urandom, $urandom});
    put_msg(4, 16'h0033, 16'h0000);
    while (pb.size() < 40) pb.push_back(8'($urandom));
    add_pkt(1000);
    nominal(); add_pkt(1000); play(0);

    // L = 50 while chain needs 60
    put_hdr($urandom, {$urandom, $urandom});
    put_msg(48, 16'h0044, 16'h0000);
    while (pb.size() > 50) void'(pb.pop_back());
    add_pkt(1000); play(0);

    // Sop mid-packet, then a full nominal packet
    put_hdr($urandom, {$urandom, $urandom});
    put_msg(20, 16'h0055, 16'h0001);
    put_msg(20, 16'h0066, 16'h0001);
    add_pkt(3);
    nominal(); add_pkt(1000); play(1);

    // Single sop+eop word, then eop with too few header bytes
    pb.delete(); repeat (5) pb.push_back(8'($urandom));
    add_pkt(1000); play(0);
    pb.delete(); repeat (10) pb.push_back(8'($urandom));
    add_pkt(1000); play(0);

    // Reset mid-packet
    nominal(); add_pkt(4); play(0);
    do_reset();
    nominal(); add_pkt(1000); play(0);

    // Index/count saturation
    put_hdr($urandom, {$urandom, $urandom});
    for (int i = 0; i < 262; i++) put_msg(10, 16'(i), 16'h0004);
    add_pkt(1000); play(0);

    // Random packets, occasional bad sizes, junk tails and aborts
    for (int t = 0; t < 30; t++) begin
      put_hdr($urandom, {$urandom, $urandom});
      nm = $urandom_range(0, 5);
      for (int m = 0; m < nm; m++) begin
        if ($urandom_range(0, 9) == 0) put_msg($urandom_range(0, 9), 16'($urandom), 16'($urandom));
        else put_msg($urandom_range(10, 40), 16'($urandom), 16'($urandom));
      end
      repeat ($urandom_range(0, 12)) pb.push_back(8'($urandom));
      nw = (pb.size() + 7) / 8;
      nsend = ($urandom_range(0, 7) == 0 && nw > 1) ? $urandom_range(1, nw - 1) : nw;
      add_pkt(nsend);
      play($urandom_range(0, 2));
    end
    nominal(); add_pkt(1000); play(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
